pdp8_mem_arbiter: RTL and testbench

Shares the single 4K x 12 PDP-8 memory port between two requesters: the CPU controller and an IOT data-break (DMA) channel. It accepts level requests, arbitrates with data-break priority plus a CPU anti-starvation limit, and drives the memory strobes. It counts a fixed memory latency and returns read data with a one-cycle done pulse to the winning requester. It sits between the CPU/IOT distributor and the memory module, in place of their direct memory connection.

---
 rtl/pdp8_mem_arbiter_pkg.sv | 19 +
 rtl/pdp8_mem_arbiter_if.sv | 45 ++++
 rtl/pdp8_mem_arbiter_pick.sv | 31 +++
 rtl/pdp8_mem_arbiter.sv | 113 +++++++++++
 tb/tb_pdp8_mem_arbiter.sv | 259 +++++++++++++++++++++++++
 5 files changed

// File: rtl/pdp8_mem_arbiter_pkg.sv
// Shared types for the PDP-8 memory-port arbiter: FSM states, owner encoding,
// and the counter width used for the latency and data-break run counters.
package pdp8_arb_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_ISSUE,
    ARB_WAIT,
    ARB_DONE
  } arb_state_t;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_DB  = 1'b1
  } owner_t;

endpackage

// File: rtl/pdp8_mem_arbiter_if.sv
// Requester + memory bus of the arbiter. slave = arbiter view,
// master = the environment (CPU, data-break channel, memory).
interface pdp8_arb_if #(
  parameter int AW = 12,
  parameter int DW = 12
);
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_addr;
  logic [DW-1:0] cpu_wdata;
  logic          cpu_done;

  logic          db_req;
  logic          db_we;
  logic [AW-1:0] db_addr;
  logic [DW-1:0] db_wdata;
  logic          db_done;

  logic [DW-1:0] rdata;
  logic [AW-1:0] mem_address;
  logic [DW-1:0] mem_write_data;
  logic          mem_read_enable;
  logic          mem_write_enable;
  logic [DW-1:0] mem_read_data;
  logic          busy;
  logic          owner;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  db_req, db_we, db_addr, db_wdata,
    input  mem_read_data,
    output cpu_done, db_done, rdata,
    output mem_address, mem_write_data, mem_read_enable, mem_write_enable,
    output busy, owner
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output db_req, db_we, db_addr, db_wdata,
    output mem_read_data,
    input  cpu_done, db_done, rdata,
    input  mem_address, mem_write_data, mem_read_enable, mem_write_enable,
    input  busy, owner
  );
endinterface

// File: rtl/pdp8_mem_arbiter_pick.sv
// Winner select: data break has priority, but after MAX_DB_RUN back-to-back
// data-break grants with the CPU waiting, the CPU gets one slot.
module pdp8_arb_pick
  import pdp8_arb_pkg::*;
#(
  parameter int MAX_DB_RUN = 4
) (
  input  logic             cpu_req_i,
  input  logic             db_req_i,
  input  logic [CNT_W-1:0] run_q_i,
  output logic             grant_o,
  output owner_t           win_o,
  output logic [CNT_W-1:0] run_d_o
);

  always_comb begin
    grant_o = cpu_req_i | db_req_i;
    win_o   = OWN_CPU;
    run_d_o = '0;
    if (cpu_req_i && db_req_i) begin
      if (run_q_i < CNT_W'(MAX_DB_RUN)) begin
        win_o   = OWN_DB;
        run_d_o = run_q_i + CNT_W'(1);
      end
    end else if (db_req_i) begin
      // uncontended data break does not count toward CPU starvation
      win_o = OWN_DB;
    end
  end

endmodule

// File: rtl/pdp8_mem_arbiter.sv
// Shares the 4K x 12 memory port between CPU and data break: grant in IDLE,
// one-cycle strobe, fixed MEM_LAT wait, one-cycle done to the owner.
module pdp8_mem_arbiter
  import pdp8_arb_pkg::*;
#(
  parameter int MEM_LAT    = 1,
  parameter int MAX_DB_RUN = 4,
  parameter int AW         = 12,
  parameter int DW         = 12
) (
  input  logic       clock,
  input  logic       resetN,
  pdp8_arb_if.slave  bus
);

  arb_state_t       state_q, state_d;
  logic [CNT_W-1:0] run_q, run_d;
  logic [CNT_W-1:0] lat_q, lat_d;
  owner_t           owner_q, owner_d;
  logic             we_q, we_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [DW-1:0]    wdata_q, wdata_d;
  logic [DW-1:0]    rdata_q, rdata_d;

  logic             grant;
  owner_t           win;
  logic [CNT_W-1:0] pick_run;

  pdp8_arb_pick #(.MAX_DB_RUN(MAX_DB_RUN)) u_pick (
    .cpu_req_i (bus.cpu_req),
    .db_req_i  (bus.db_req),
    .run_q_i   (run_q),
    .grant_o   (grant),
    .win_o     (win),
    .run_d_o   (pick_run)
  );

  always_ff @(posedge clock) begin
    if (!resetN) begin
      state_q <= ARB_IDLE;
      run_q   <= '0;
      lat_q   <= '0;
      owner_q <= OWN_CPU;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      lat_q   <= lat_d;
      owner_q <= owner_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    lat_d   = lat_q;
    owner_d = owner_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (grant) begin
          state_d = ARB_ISSUE;
          run_d   = pick_run;
          owner_d = win;
          if (win == OWN_DB) begin
            we_d    = bus.db_we;
            addr_d  = bus.db_addr;
            wdata_d = bus.db_wdata;
          end else begin
            we_d    = bus.cpu_we;
            addr_d  = bus.cpu_addr;
            wdata_d = bus.cpu_wdata;
          end
        end
      end
      ARB_ISSUE: begin
        state_d = ARB_WAIT;
        lat_d   = CNT_W'(MEM_LAT);
      end
      ARB_WAIT: begin
        lat_d = lat_q - CNT_W'(1);
        if (lat_q == CNT_W'(1)) begin
          state_d = ARB_DONE;
          // memory data is only guaranteed valid in the final wait cycle
          if (!we_q) rdata_d = bus.mem_read_data;
        end
      end
      ARB_DONE: state_d = ARB_IDLE;
      default:  state_d = ARB_IDLE;
    endcase
  end

  assign bus.mem_read_enable  = (state_q == ARB_ISSUE) && !we_q;
  assign bus.mem_write_enable = (state_q == ARB_ISSUE) &&  we_q;
  assign bus.cpu_done         = (state_q == ARB_DONE) && (owner_q == OWN_CPU);
  assign bus.db_done          = (state_q == ARB_DONE) && (owner_q == OWN_DB);
  assign bus.busy             = (state_q != ARB_IDLE);
  assign bus.owner            = owner_q;
  assign bus.mem_address      = addr_q;
  assign bus.mem_write_data   = wdata_q;
  assign bus.rdata            = rdata_q;

endmodule

// File: tb/tb_pdp8_mem_arbiter.sv
// Scoreboard bench: a cycle-level transaction model predicts each strobe and
// done at grant time; a negedge monitor pops and compares what the DUT shows.
module tb_pdp8_mem_arbiter;
  localparam int L    = 3;
  localparam int MAXR = 4;
  localparam int AW   = 12;
  localparam int DW   = 12;

  logic clock = 1'b0;
  logic resetN = 1'b0;
  always #5 clock = ~clock;

  pdp8_arb_if #(.AW(AW), .DW(DW)) bus ();

  pdp8_mem_arbiter #(.MEM_LAT(L), .MAX_DB_RUN(MAXR), .AW(AW), .DW(DW)) dut (
    .clock  (clock),
    .resetN (resetN),
    .bus    (bus)
  );

  // memory seen by the DUT, and the model's own copy
  logic [DW-1:0] mem     [0:4095];
  logic [DW-1:0] ref_mem [0:4095];
  assign bus.mem_read_data = mem[bus.mem_address];
  always @(posedge clock) if (bus.mem_write_enable) mem[bus.mem_address] <= bus.mem_write_data;

  // requester drive: index 0 = CPU, 1 = data break
  logic          rq   [2];
  logic          rwe  [2];
  logic [AW-1:0] raddr[2];
  logic [DW-1:0] rwd  [2];
  assign bus.cpu_req   = rq[0];
  assign bus.cpu_we    = rwe[0];
  assign bus.cpu_addr  = raddr[0];
  assign bus.cpu_wdata = rwd[0];
  assign bus.db_req    = rq[1];
  assign bus.db_we     = rwe[1];
  assign bus.db_addr   = raddr[1];
  assign bus.db_wdata  = rwd[1];

  typedef struct { int cyc; logic we; logic [AW-1:0] addr; logic [DW-1:0] wd; } stb_t;
  typedef struct { int cyc; logic own; logic [DW-1:0] rd; } dn_t;
  stb_t sq[$];
  dn_t  dq[$];

  int n_chk = 0, n_fail = 0;
  int cyc = 0;
  logic rst_edge = 1'b1;
  always @(posedge clock) begin
    cyc      <= cyc + 1;
    rst_edge <= !resetN;
  end

  task automatic chk(input string nm, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // model state
  int   free_c = 0, busy_lo = -1, busy_hi = -1, ref_run = 0;
  logic ref_own = 1'b0;
  logic [DW-1:0] ref_rd = '0;

  // monitor observations
  int   done_cnt[2] = '{0, 0};
  int   stb_hist[$];
  int   last_done_cyc = -1;
  logic [DW-1:0] last_done_rd = '0;
  logic rec_en = 1'b0;
  logic seq[$];

  always @(negedge clock) begin
    int c, w;
    logic es, as, ed, ad;
    stb_t s;
    dn_t  d;
    logic [DW-1:0] rd;
    c = cyc;
    if (rst_edge)
      chk("reset_outputs_zero",
          {bus.busy, bus.owner, bus.cpu_done, bus.db_done, bus.mem_read_enable,
           bus.mem_write_enable, bus.mem_address, bus.mem_write_data, bus.rdata}, 0);

    es = (sq.size() > 0) && (sq[0].cyc == c);
    as = bus.mem_read_enable | bus.mem_write_enable;
    if (as) stb_hist.push_back(c);
    if (es || as) chk("strobe_present", as, es);
    if (es) begin
      s = sq.pop_front();
      if (as) begin
        chk("strobe_kind", {bus.mem_read_enable, bus.mem_write_enable}, s.we ? 2'b01 : 2'b10);
        chk("strobe_addr", bus.mem_address, s.addr);
        if (s.we) chk("strobe_wdata", bus.mem_write_data, s.wd);
      end
    end

    ed = (dq.size() > 0) && (dq[0].cyc == c);
    ad = bus.cpu_done | bus.db_done;
    if (ad) begin
      if (bus.cpu_done) done_cnt[0]++;
      if (bus.db_done) done_cnt[1]++;
      last_done_cyc = c;
      last_done_rd  = bus.rdata;
      if (rec_en) seq.push_back(bus.db_done);
    end
    if (ed || ad) chk("done_present", ad, ed);
    if (ed) begin
      d = dq.pop_front();
      if (ad) begin
        chk("done_owner", {bus.cpu_done, bus.db_done}, d.own ? 2'b01 : 2'b10);
        chk("done_rdata", bus.rdata, d.rd);
      end
    end

    if (!rst_edge) begin
      chk("busy", bus.busy, (c >= busy_lo) && (c <= busy_hi));
      if ((c >= busy_lo) && (c <= busy_hi)) chk("owner", bus.owner, ref_own);
    end

    // reference model: at most one transaction in flight, winner chosen when free
    if (!resetN) begin
      sq.delete(); dq.delete();
      ref_run = 0; ref_rd = '0; ref_own = 1'b0;
      free_c = c + 1; busy_hi = c;
    end else if (c >= free_c && (rq[0] || rq[1])) begin
      if (rq[0] && rq[1]) begin
        if (ref_run < MAXR) begin w = 1; ref_run++; end
        else begin w = 0; ref_run = 0; end
      end else begin
        w = rq[1] ? 1 : 0;
        ref_run = 0;
      end
      if (rwe[w]) begin
        rd = ref_rd;
        ref_mem[raddr[w]] = rwd[w];
      end else begin
        rd = ref_mem[raddr[w]];
        ref_rd = rd;
      end
      sq.push_back('{c + 1, rwe[w], raddr[w], rwd[w]});
      dq.push_back('{c + L + 2, w[0], rd});
      ref_own = w[0];
      busy_lo = c + 1; busy_hi = c + L + 2; free_c = c + L + 3;
    end
  end

  // ---------------- stimulus ----------------
  int   seen[2] = '{0, 0};
  logic keep_all[2] = '{1'b0, 1'b0};
  logic keep_once[2] = '{1'b0, 1'b0};
  logic rnd_en = 1'b0;

  task automatic new_txn(input int id);
    rq[id]    = 1'b1;
    rwe[id]   = 1'($urandom_range(1));
    raddr[id] = AW'(12'o100 + $urandom_range(7));
    rwd[id]   = DW'($urandom);
  endtask

  task automatic start(input int id, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] wd);
    rq[id] = 1'b1; rwe[id] = we; raddr[id] = a; rwd[id] = wd;
  endtask

  // requesters drop req (or chain a new request) on the edge that ends done
  task automatic step();
    @(posedge clock); #1;
    for (int id = 0; id < 2; id++) begin
      if (done_cnt[id] != seen[id]) begin
        seen[id] = done_cnt[id];
        if (keep_all[id] || keep_once[id] || (rnd_en && $urandom_range(3) == 0)) begin
          keep_once[id] = 1'b0;
          new_txn(id);
        end else rq[id] = 1'b0;
      end else if (rnd_en && !rq[id] && $urandom_range(2) == 0) new_txn(id);
    end
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while ((rq[0] || rq[1]) && n < budget) begin step(); n++; end
    if (rq[0] || rq[1]) chk("wait_idle_timeout", 1, 0);
    repeat (L + 4) step();
  endtask

  initial begin
    int s, d0;
    logic [9:0] got;
    for (int i = 0; i < 2; i++) begin rq[i] = 0; rwe[i] = 0; raddr[i] = '0; rwd[i] = '0; end
    for (int i = 0; i < 4096; i++) begin mem[i] = DW'($urandom); ref_mem[i] = mem[i]; end
    mem[12'o200] = 12'o7402; ref_mem[12'o200] = 12'o7402;
    repeat (3) @(posedge clock);
    #1 resetN = 1'b1;
    step();

    // CPU read
    s = cyc; start(0, 1'b0, 12'o200, '0);
    wait_idle(50);
    chk("t1_strobe_cycle", stb_hist[$], s + 1);
    chk("t1_done_cycle", last_done_cyc, s + L + 2);
    chk("t1_rdata", last_done_rd, 12'o7402);

    // DB write then CPU read-back
    s = cyc; start(1, 1'b1, 12'o017, 12'o1234);
    wait_idle(50);
    chk("t2_done_cycle", last_done_cyc, s + L + 2);
    chk("t2_rdata_unchanged", last_done_rd, 12'o7402);
    start(0, 1'b0, 12'o017, '0);
    wait_idle(50);
    chk("t2_readback", last_done_rd, 12'o1234);

    // reset in WAIT of a CPU read; held request restarts from scratch
    d0 = done_cnt[0];
    s = cyc; start(0, 1'b0, 12'o200, '0);
    step(); step();
    resetN = 1'b0;
    step();
    resetN = 1'b1;
    wait_idle(50);
    chk("t3_single_done", done_cnt[0], d0 + 1);
    chk("t3_done_cycle", last_done_cyc, s + 3 + L + 2);

    // req held past done becomes a second transaction
    keep_once[0] = 1'b1;
    start(0, 1'b0, 12'o200, '0);
    wait_idle(100);
    chk("t4_strobe_spacing", stb_hist[$] - stb_hist[$-1], L + 3);

    // both continuously: fresh run count, simultaneous first request
    resetN = 1'b0; step(); resetN = 1'b1; step();
    seq.delete(); rec_en = 1'b1;
    keep_all[0] = 1'b1; keep_all[1] = 1'b1;
    start(0, 1'b0, 12'o201, '0);
    start(1, 1'b0, 12'o202, '0);
    step(); step();
    raddr[0] = 12'o305;
    for (int n = 0; n < 300 && seq.size() < 10; n++) step();
    keep_all[0] = 1'b0; keep_all[1] = 1'b0; rec_en = 1'b0;
    chk("t5_grant_count", seq.size() >= 10, 1);
    got = '0;
    for (int i = 0; i < 10 && i < seq.size(); i++) got[9-i] = seq[i];
    chk("t5_grant_order", got, 10'b1111011110);
    wait_idle(100);

    // randomized traffic
    rnd_en = 1'b1;
    repeat (800) step();
    rnd_en = 1'b0;
    wait_idle(200);
    chk("queues_drained", sq.size() + dq.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
